// File: rtl/feature_unpacker.sv
// Buffers packed MFCC vectors ({last, 13 x 8-bit}) in a FIFO and serialises
// them MSB byte first as signed coefficients under a valid/ready handshake.
module feature_unpacker #(
    parameter int ELEM_BW   = 8,
    parameter int NUM_ELEMS = 13,
    parameter int I_BW      = ELEM_BW * NUM_ELEMS,
    parameter int DEPTH     = 64,
    parameter int IDX_BW    = $clog2(NUM_ELEMS)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      en_i,
    input  logic [I_BW-1:0]           data_i,
    input  logic                      valid_i,
    input  logic                      last_i,
    output logic signed [ELEM_BW-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      last_o,
    output logic [IDX_BW-1:0]         elem_idx_o,
    output logic                      overflow_o
);

    localparam int PTR_BW = $clog2(DEPTH);
    localparam int CNT_BW = PTR_BW + 1;
    localparam int ENT_BW = I_BW + 1;
    localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM_ELEMS - 1);
    localparam logic [CNT_BW-1:0] FULL_CNT = CNT_BW'(DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, SERIAL = 1'b1} state_t;

    logic [ENT_BW-1:0]  mem_q [DEPTH];
    logic [PTR_BW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BW-1:0]  cnt_q, cnt_d;
    state_t             state_q, state_d;
    logic [IDX_BW-1:0]  idx_q, idx_d;
    logic [I_BW-1:0]    vec_q, vec_d;
    logic               vlast_q, vlast_d;
    logic [ELEM_BW-1:0] data_q, data_d;
    logic               last_q, last_d;
    logic               ovf_q, ovf_d;
    logic               empty_s, full_s, push_s, pop_s;
    logic [ENT_BW-1:0]  rd_entry_s;

    function automatic logic [ELEM_BW-1:0] elem_sel(input logic [I_BW-1:0] vec,
                                                    input logic [IDX_BW-1:0] idx);
        logic [ELEM_BW-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_ELEMS; k++) begin
            if (idx == IDX_BW'(k)) begin
                r = vec[I_BW-1-k*ELEM_BW -: ELEM_BW];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign empty_s    = (cnt_q == '0);
    assign full_s     = (cnt_q == FULL_CNT);
    assign rd_entry_s = mem_q[rd_ptr_q];

    // Serialiser next state, FIFO bookkeeping and next output values.
    always_comb begin
        pop_s   = 1'b0;
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        vlast_d = vlast_q;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s              = 1'b1;
                    state_d            = SERIAL;
                    idx_d              = '0;
                    {vlast_d, vec_d}   = rd_entry_s;
                end else begin
                    state_d = IDLE;
                end
            end
            SERIAL: begin
                if (ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (!empty_s) begin
                            pop_s            = 1'b1;
                            {vlast_d, vec_d} = rd_entry_s;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_BW'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
        push_s   = valid_i & (~full_s | pop_s);
        wr_ptr_d = push_s ? wr_ptr_q + PTR_BW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + PTR_BW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_BW'(1);
            2'b01:   cnt_d = cnt_q - CNT_BW'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q | (valid_i & full_s & ~pop_s);

        if (state_d == SERIAL) begin
            data_d = elem_sel(vec_d, idx_d);
            last_d = (idx_d == LAST_IDX) & vlast_d;
        end else begin
            data_d = '0;
            last_d = 1'b0;
        end
    end

    // FIFO storage; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (en_i && push_s) begin
            mem_q[wr_ptr_q] <= {last_i, data_i};
        end
    end

    // State registers with async reset and en_i-low synchronous flush.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            idx_q    <= '0;
            vec_q    <= '0;
            vlast_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (!en_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            idx_q    <= '0;
            vec_q    <= '0;
            vlast_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            vec_q    <= vec_d;
            vlast_q  <= vlast_d;
            data_q   <= data_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = (state_q == SERIAL);
    assign last_o     = last_q;
    assign elem_idx_o = idx_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_feature_unpacker.sv
// Directed self-checking bench for feature_unpacker: one task per scenario,
// inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_feature_unpacker;
    localparam int EB = 8;
    localparam int NE = 13;
    localparam int IB = EB * NE;
    localparam int IX = 4;

    logic                 clk = 1'b0;
    logic                 rst_n, en, valid_i, last_i, ready;
    logic [IB-1:0]        data_i;
    logic signed [EB-1:0] data_o;
    logic                 valid_o, last_o, ovf;
    logic [IX-1:0]        idx_o;
    int                   total = 0;
    int                   bad = 0;

    feature_unpacker #(.ELEM_BW(EB), .NUM_ELEMS(NE), .DEPTH(64)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .data_i(data_i), .valid_i(valid_i),
        .last_i(last_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready),
        .last_o(last_o), .elem_idx_o(idx_o), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mkel(input int j, input int k);
        return 8'((j * 7 + k * 3 + 1) & 255);
    endfunction

    function automatic logic [IB-1:0] mkvec(input int j);
        logic [IB-1:0] v;
        v = '0;
        for (int k = 0; k < NE; k++) v[IB-1-k*EB -: EB] = mkel(j, k);
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; valid_i = 1'b0; last_i = 1'b0; ready = 1'b0; data_i = '0;
        repeat (2) @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h exp=0", data_o); end
        total++; if (last_o !== 1'b0) begin bad++; $display("FAIL reset_last got=%0b exp=0", last_o); end
        total++; if (idx_o !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx_o); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
        tick; rst_n = 1'b1; tick;
    endtask

    task automatic test_single;
        data_i = 104'h0102030405060708090A0B0C0D; valid_i = 1'b1; last_i = 1'b1; ready = 1'b1;
        @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL single_c0 valid got=%0b exp=0", valid_o); end
        tick; valid_i = 1'b0; last_i = 1'b0;
        @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL single_c1 valid got=%0b exp=0", valid_o); end
        for (int k = 0; k < NE; k++) begin
            tick; @(negedge clk);
            total++;
            if (valid_o !== 1'b1 || data_o !== 8'(k + 1) || idx_o !== IX'(k) || last_o !== (k == 12)) begin
                bad++;
                $display("FAIL single_elem k=%0d got v=%0b d=%0h i=%0d l=%0b exp v=1 d=%0h i=%0d l=%0b",
                         k, valid_o, data_o, idx_o, last_o, 8'(k + 1), k, (k == 12));
            end
        end
        tick; @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL single_end valid got=%0b exp=0", valid_o); end
        tick;
    endtask

    task automatic test_burst;
        int got = 0, lasts = 0, first_t = -1;
        bit started = 1'b0;
        ready = 1'b1;
        for (int t = 0; t < 720 && got < 650; t++) begin
            valid_i = (t < 50); data_i = mkvec(t); last_i = (t == 49);
            @(negedge clk);
            if (started && got < 650) begin
                total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL burst_bubble at got=%0d valid=%0b exp=1", got, valid_o); end
            end
            if (valid_o === 1'b1) begin
                if (!started) first_t = t;
                started = 1'b1;
                total++;
                if (data_o !== mkel(got / 13, got % 13) || idx_o !== IX'(got % 13) || last_o !== (got == 649)) begin
                    bad++;
                    $display("FAIL burst_elem n=%0d got d=%0h i=%0d l=%0b exp d=%0h i=%0d l=%0b", got, data_o, idx_o,
                             last_o, mkel(got / 13, got % 13), got % 13, (got == 649));
                end
                if (last_o) lasts++;
                got++;
            end
            tick;
        end
        valid_i = 1'b0; last_i = 1'b0;
        total++; if (first_t != 2) begin bad++; $display("FAIL burst_latency got=%0d exp=2", first_t); end
        total++; if (got != 650) begin bad++; $display("FAIL burst_count got=%0d exp=650", got); end
        total++; if (lasts != 1) begin bad++; $display("FAIL burst_lasts got=%0d exp=1", lasts); end
        @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL burst_end valid got=%0b exp=0", valid_o); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL burst_ovf got=%0b exp=0", ovf); end
        tick;
    endtask

    task automatic test_backpressure;
        logic [7:0] lfsr = 8'hA5;
        logic pv = 1'b0, pr = 1'b1, pl = 1'b0;
        logic signed [7:0] pd = 8'sh00;
        logic [IX-1:0] pi = '0;
        int got = 0;
        for (int t = 0; t < 300 && got < 26; t++) begin
            valid_i = (t < 2); data_i = mkvec(60 + t); last_i = (t == 1);
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            ready = lfsr[0];
            @(negedge clk);
            if (pv && !pr) begin
                total++;
                if (valid_o !== 1'b1 || data_o !== pd || idx_o !== pi || last_o !== pl) begin
                    bad++;
                    $display("FAIL bp_hold got d=%0h i=%0d l=%0b exp d=%0h i=%0d l=%0b", data_o, idx_o, last_o, pd, pi, pl);
                end
            end
            if (valid_o && ready) begin
                total++;
                if (data_o !== mkel(60 + got / 13, got % 13) || idx_o !== IX'(got % 13) || last_o !== (got == 25)) begin
                    bad++;
                    $display("FAIL bp_elem n=%0d got d=%0h i=%0d l=%0b exp d=%0h i=%0d l=%0b", got, data_o, idx_o,
                             last_o, mkel(60 + got / 13, got % 13), got % 13, (got == 25));
                end
                got++;
            end
            pv = valid_o; pr = ready; pd = data_o; pi = idx_o; pl = last_o;
            tick;
        end
        valid_i = 1'b0; last_i = 1'b0; ready = 1'b1;
        total++; if (got != 26) begin bad++; $display("FAIL bp_count got=%0d exp=26", got); end
        @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL bp_end valid got=%0b exp=0", valid_o); end
        tick;
    endtask

    task automatic test_overflow;
        int got = 0;
        ready = 1'b0;
        for (int t = 0; t < 66; t++) begin
            valid_i = 1'b1; data_i = mkvec(100 + t); last_i = (t >= 64);
            @(negedge clk);
            if (t == 65) begin
                total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", ovf); end
            end
            tick;
        end
        valid_i = 1'b0; last_i = 1'b0;
        @(negedge clk);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", ovf); end
        tick; ready = 1'b1;
        for (int c = 0; c < 1000 && got < 845; c++) begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                total++;
                if (data_o !== mkel(100 + got / 13, got % 13) || idx_o !== IX'(got % 13) || last_o !== (got == 844)) begin
                    bad++;
                    $display("FAIL ovf_drain n=%0d got d=%0h i=%0d l=%0b exp d=%0h i=%0d l=%0b", got, data_o, idx_o,
                             last_o, mkel(100 + got / 13, got % 13), got % 13, (got == 844));
                end
                got++;
            end
            tick;
        end
        total++; if (got != 845) begin bad++; $display("FAIL ovf_count got=%0d exp=845", got); end
        @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL ovf_end valid got=%0b exp=0", valid_o); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", ovf); end
        tick; en = 1'b0; tick; en = 1'b1;
        @(negedge clk);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", ovf); end
        tick;
    endtask

    task automatic test_full_plus_pop;
        int got = 14;
        ready = 1'b0;
        for (int t = 0; t < 65; t++) begin
            valid_i = 1'b1; data_i = mkvec(200 + t); last_i = 1'b0;
            tick;
        end
        valid_i = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < NE; k++) begin
            if (k == 12) begin valid_i = 1'b1; data_i = mkvec(265); last_i = 1'b1; end
            @(negedge clk);
            total++;
            if (valid_o !== 1'b1 || idx_o !== IX'(k) || data_o !== mkel(200, k)) begin
                bad++;
                $display("FAIL fpp_first k=%0d got v=%0b d=%0h i=%0d exp v=1 d=%0h i=%0d", k, valid_o, data_o, idx_o, mkel(200, k), k);
            end
            tick;
            valid_i = 1'b0; last_i = 1'b0;
        end
        @(negedge clk);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%0b exp=0", ovf); end
        total++;
        if (valid_o !== 1'b1 || idx_o !== 4'd0 || data_o !== mkel(201, 0)) begin
            bad++; $display("FAIL fpp_nobubble got v=%0b d=%0h i=%0d exp v=1 d=%0h i=0", valid_o, data_o, idx_o, mkel(201, 0));
        end
        tick;
        for (int c = 0; c < 1200 && got < 858; c++) begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                total++;
                if (data_o !== mkel(200 + got / 13, got % 13) || idx_o !== IX'(got % 13) || last_o !== (got == 857)) begin
                    bad++;
                    $display("FAIL fpp_drain n=%0d got d=%0h i=%0d l=%0b exp d=%0h i=%0d l=%0b", got, data_o, idx_o,
                             last_o, mkel(200 + got / 13, got % 13), got % 13, (got == 857));
                end
                got++;
            end
            tick;
        end
        total++; if (got != 858) begin bad++; $display("FAIL fpp_count got=%0d exp=858", got); end
        @(negedge clk);
        total++; if (ovf !== 1'b0 || valid_o !== 1'b0) begin bad++; $display("FAIL fpp_end got ovf=%0b v=%0b exp 0 0", ovf, valid_o); end
        tick;
    endtask

    task automatic test_restart(input int j);
        valid_i = 1'b1; data_i = mkvec(j); last_i = 1'b1;
        @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL restart_c0 valid got=%0b exp=0", valid_o); end
        tick; valid_i = 1'b0; last_i = 1'b0;
        for (int k = 0; k < NE; k++) begin
            tick; @(negedge clk);
            total++;
            if (valid_o !== 1'b1 || data_o !== mkel(j, k) || idx_o !== IX'(k) || last_o !== (k == 12)) begin
                bad++;
                $display("FAIL restart_elem k=%0d got v=%0b d=%0h i=%0d l=%0b exp v=1 d=%0h i=%0d l=%0b",
                         k, valid_o, data_o, idx_o, last_o, mkel(j, k), k, (k == 12));
            end
        end
        tick;
    endtask

    task automatic test_flush;
        ready = 1'b1;
        valid_i = 1'b1; data_i = mkvec(300); last_i = 1'b0; tick;
        data_i = mkvec(301); tick;
        valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin @(negedge clk); tick; end
        en = 1'b0; valid_i = 1'b1; data_i = mkvec(302);
        @(negedge clk);
        total++; if (idx_o !== 4'd5 || valid_o !== 1'b1) begin bad++; $display("FAIL flush_pre got i=%0d v=%0b exp i=5 v=1", idx_o, valid_o); end
        tick; en = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        total++;
        if (valid_o !== 1'b0 || idx_o !== 4'd0 || ovf !== 1'b0 || last_o !== 1'b0) begin
            bad++; $display("FAIL flush_clear got v=%0b i=%0d o=%0b l=%0b exp all 0", valid_o, idx_o, ovf, last_o);
        end
        tick; @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_empty valid got=%0b exp=0", valid_o); end
        tick;
        test_restart(303);
    endtask

    task automatic test_async_reset;
        ready = 1'b1;
        valid_i = 1'b1; data_i = mkvec(400); last_i = 1'b1; tick;
        valid_i = 1'b0; last_i = 1'b0;
        for (int k = 0; k < 6; k++) begin @(negedge clk); tick; end
        @(negedge clk);
        total++; if (idx_o !== 4'd5 || valid_o !== 1'b1) begin bad++; $display("FAIL arst_pre got i=%0d v=%0b exp i=5 v=1", idx_o, valid_o); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (valid_o !== 1'b0 || idx_o !== 4'd0 || data_o !== 8'h00 || last_o !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL arst_now got v=%0b i=%0d d=%0h l=%0b o=%0b exp all 0", valid_o, idx_o, data_o, last_o, ovf);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick;
        test_restart(401);
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_backpressure;
        test_overflow;
        test_full_plus_pop;
        test_flush;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/feature_unpacker.md
# feature_unpacker

Receive-side counterpart of the acoustic featurisation pipeline's packed output. It accepts packed MFCC feature vectors (13 × 8-bit coefficients in one 104-bit word, with valid/last framing) and buffers them in a FIFO. It then serialises each vector back into individual signed 8-bit coefficients under a valid/ready handshake for the downstream word-recognition datapath. `last_o` marks the final coefficient of the final vector of each window.

## Interface

**Parameters**
- `ELEM_BW`, default 8: coefficient width.
- `NUM_ELEMS`, default 13: coefficients per packed vector.
- `I_BW`, default `ELEM_BW*NUM_ELEMS` (104): packed input width.
- `DEPTH`, default 64: FIFO depth in vectors. Must be a power of two and ≥ 50 so one full window fits.
- `IDX_BW`, default `$clog2(NUM_ELEMS)` (4): element index width.

**Ports** (name, direction, width, meaning)
- `clk_i`, in, 1: clock; single clock domain.
- `rst_n_i`, in, 1: reset, asynchronous, active-low.
- `en_i`, in, 1: block enable; low = synchronous flush.
- `data_i`, in, `I_BW`: packed vector.
- `valid_i`, in, 1: `data_i` valid. No backpressure on the input side.
- `last_i`, in, 1: vector is the last of its window.
- `data_o`, out, `ELEM_BW`: current coefficient, signed.
- `valid_o`, out, 1: `data_o` valid.
- `ready_i`, in, 1: downstream accepts `data_o`.
- `last_o`, out, 1: final coefficient of a last-flagged vector.
- `elem_idx_o`, out, `IDX_BW`: index of the current coefficient, 0..`NUM_ELEMS`-1.
- `overflow_o`, out, 1: sticky; a vector was dropped because the FIFO was full.

## Operation

- **Element ordering.** Element k = `data_i[I_BW-1-k*ELEM_BW -: ELEM_BW]`. Element 0 (the MSB byte) is emitted first.
- **FIFO.** Storage is `DEPTH` × (`I_BW`+1). Each entry holds {`last_i`, `data_i`}. The FIFO uses binary read/write pointers plus a count register of `$clog2(DEPTH)+1` bits.
- **Push.** Occurs on `en_i & valid_i & (!full | pop)`. A simultaneous pop frees a slot, so a push while full is accepted.
- **Drop.** `en_i & valid_i & full & !pop` drops the vector, does not modify the FIFO, and sets `overflow_o`.
- **Serialiser FSM.** State `IDLE`: no vector loaded, `valid_o` = 0. State `SERIAL`: holds one vector plus its last flag; `valid_o` = 1.
- **IDLE → SERIAL:** FIFO non-empty. Pop the entry, `idx` ← 0.
- **SERIAL, handshake (`valid_o & ready_i`), `idx` < `NUM_ELEMS`-1:** `idx` ← `idx`+1.
- **SERIAL, handshake, `idx` = `NUM_ELEMS`-1, FIFO non-empty:** pop the next entry, `idx` ← 0, remain in SERIAL. No bubble between vectors.
- **SERIAL, handshake, `idx` = `NUM_ELEMS`-1, FIFO empty:** → IDLE.
- **SERIAL, `ready_i` low:** `data_o`, `elem_idx_o` and `last_o` hold stable.
- **Output decode.** `data_o` = selected byte of the held vector. `elem_idx_o` = `idx`. `last_o` = `valid_o & (idx == NUM_ELEMS-1) & held_last`.
- **Enable low.** `en_i` = 0 at a clock edge clears the pointers, count, FSM (→ IDLE), `idx` and `overflow_o`. Input is ignored while `en_i` is low, and `valid_o` is 0 in the following cycle.
- **Reset.** Asynchronous assertion of `rst_n_i` forces the same cleared state immediately, including mid-vector. FIFO storage contents are not reset.

## Timing

- **Reset values:** `data_o` = 0, `valid_o` = 0, `last_o` = 0, `elem_idx_o` = 0, `overflow_o` = 0.
- **Latency.** With the FIFO empty and the FSM idle, `valid_i` high in cycle c gives element 0 on `data_o` with `valid_o` = 1 in cycle c+2. The cycle c+1 edge pops the entry.
- **Throughput.** One coefficient per cycle while `ready_i` is high. A vector occupies exactly `NUM_ELEMS` handshake cycles.
- **Overflow timing.** `overflow_o` rises the cycle after the dropping edge. It is cleared only by reset or by `en_i` low.
- **Output stability.** While `valid_o` is high and `ready_i` is low, all outputs are stable.

## Test plan

- **Single vector.** One vector 0x0102…0D with `last_i` = 1, `ready_i` = 1. Expect `valid_o` two cycles later, then 13 consecutive cycles of `data_o` = 0x01..0x0D with `elem_idx_o` 0..12. `last_o` is high only at index 12, then `valid_o` = 0.
- **Window burst.** 50 back-to-back vectors, `last_i` on the 50th, `ready_i` = 1. Expect 650 contiguous valid cycles with no bubbles, the correct byte order per vector, and `last_o` exactly once (cycle 650). `overflow_o` stays 0.
- **Backpressure.** Toggle `ready_i` pseudo-randomly during two vectors. Every coefficient is delivered exactly once, in order. Outputs hold steady while `ready_i` = 0.
- **Overflow.** Hold `ready_i` = 0, push 65 vectors with `DEPTH` = 64. The first vector sits in the serialiser, so all 65 are accepted. A 66th is dropped and `overflow_o` = 1 the next cycle. Releasing `ready_i` yields vectors 1..65 in order.
- **Full-plus-pop.** With the FIFO full and the last coefficient of a vector handshaking, push a vector in the same cycle. It is accepted and `overflow_o` stays 0.
- **Flush mid-stream.** Deassert `en_i` for one cycle at `elem_idx_o` = 5, then re-enable. Expect `valid_o` = 0, the FIFO empty, and `overflow_o` = 0. A new vector then serialises from index 0. Repeat with asynchronous `rst_n_i` assertion: outputs go to reset values immediately.
